// File: rtl/ysyx_25060170_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, RV32 funct3
// size/sign encodings and the bus-timeout counter width.
package ysyx_25060170_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned TO_W = 8;
    localparam logic [TO_W-1:0] TIMEOUT_DEF = 8'd255;

    // Unsigned sizes only make sense for loads; 011 and 11x are never legal.
    function automatic logic f3_bad(input logic [2:0] f3, input logic is_store);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = is_store;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_25060170_lsu_align.sv
// Byte-lane steering for the data bus: store strobes/replication, alignment
// checks and extraction plus sign/zero extension of load data.
module ysyx_25060170_lsu_align
    import ysyx_25060170_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        store_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic        f3_bad_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    assign f3_bad_o = f3_bad(funct3_i, store_i);

    always_comb begin
        wmask_o    = 4'b0000;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_B: begin
                wmask_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_BU: begin
                rdata_o = {24'h000000, byte_sel};
            end
            F3_H: begin
                misalign_o = addr_lo_i[0];
                wmask_o    = 4'b0011 << addr_lo_i;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{half_sel[15]}}, half_sel};
            end
            F3_HU: begin
                misalign_o = addr_lo_i[0];
                rdata_o    = {16'h0000, half_sel};
            end
            F3_W: begin
                misalign_o = |addr_lo_i;
                wmask_o    = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit: one access at a time from EXU onto a single-port data bus,
// returning extended load data (or an error flag) to WBU.
//
//  state  | meaning
//  IDLE   | ready for the next instruction from EXU
//  REQ    | bus request raised, waiting for grant
//  WAIT   | granted, waiting for response
//  DONE   | result presented to WBU until consumed
module ysyx_25060170_lsu
    import ysyx_25060170_lsu_pkg::*;
#(
    parameter logic [TO_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] mem_data_o,
    output logic        err_o
);

    lsu_state_e      state_q, state_d;
    logic [31:0]     addr_q, wdata_q, data_q;
    logic [2:0]      f3_q;
    logic            rd_q, wr_q, err_q;
    logic [TO_W-1:0] cnt_q;

    logic            accept, in_err, capture, timeout, in_req;
    logic            use_live;
    logic [2:0]      al_f3;
    logic [1:0]      al_lo;
    logic            al_store;
    logic [3:0]      lane_wmask;
    logic [31:0]     lane_wdata, load_data;
    logic            al_misalign, al_f3_bad;

    // In IDLE the checker looks at the incoming instruction; afterwards it
    // works on the latched copy so bus fields stay stable.
    assign use_live = (state_q == S_IDLE);
    assign al_f3    = use_live ? funct3_i     : f3_q;
    assign al_lo    = use_live ? addr_i[1:0]  : addr_q[1:0];
    assign al_store = use_live ? mem_wr_i     : wr_q;

    ysyx_25060170_lsu_align u_align (
        .funct3_i   (al_f3),
        .addr_lo_i  (al_lo),
        .store_i    (al_store),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata_i),
        .wmask_o    (lane_wmask),
        .wdata_o    (lane_wdata),
        .misalign_o (al_misalign),
        .f3_bad_o   (al_f3_bad),
        .rdata_o    (load_data)
    );

    assign in_ready_o = (state_q == S_IDLE);
    assign accept     = in_valid_i & in_ready_o;
    assign in_err     = (mem_rd_i & mem_wr_i)
                      | ((mem_rd_i ^ mem_wr_i) & (al_misalign | al_f3_bad));

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!(mem_rd_i | mem_wr_i) || in_err) state_d = S_DONE;
                    else                                  state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i && mem_rvalid_i) begin
                    state_d = S_DONE;
                    capture = 1'b1;
                end else if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end else if (cnt_q >= TIMEOUT - 1'b1) begin
                    state_d = S_DONE;
                    timeout = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = S_DONE;
                    capture = 1'b1;
                end else if (cnt_q >= TIMEOUT - 1'b1) begin
                    state_d = S_DONE;
                    timeout = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                f3_q    <= funct3_i;
                rd_q    <= mem_rd_i;
                wr_q    <= mem_wr_i;
                cnt_q   <= '0;
                data_q  <= '0;
                err_q   <= in_err;
            end else if (state_q == S_REQ || state_q == S_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (capture && rd_q) data_q <= load_data;
                if (timeout) begin
                    err_q  <= 1'b1;
                    data_q <= '0;
                end
            end
        end
    end

    assign in_req      = (state_q == S_REQ);
    assign mem_req_o   = in_req;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wen_o   = in_req & wr_q;
    assign mem_wmask_o = (in_req && wr_q) ? lane_wmask : 4'b0000;
    assign mem_wdata_o = (in_req && wr_q) ? lane_wdata : 32'h0;
    assign out_valid_o = (state_q == S_DONE);
    assign mem_data_o  = data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Bench for the load/store unit: table of transactions with a result
// scoreboard, plus hand sequences for timeout and reset mid-access.
module tb_ysyx_25060170_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [2:0]  funct3_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] mem_data_o;
    logic        err_o;

    ysyx_25060170_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .funct3_i     (funct3_i),
        .mem_rd_i     (mem_rd_i),
        .mem_wr_i     (mem_wr_i),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wen_o    (mem_wen_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .mem_data_o   (mem_data_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        bit          rv_same;
        int          hold;
        bit          exp_req;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                input int gd, input bit rvs, input int hold, input bit req,
                                input logic [3:0] m, input logic [31:0] ewd, input logic [31:0] ed,
                                input bit er);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
        v.gnt_dly = gd; v.rv_same = rvs; v.hold = hold; v.exp_req = req; v.exp_mask = m;
        v.exp_wdata = ewd; v.exp_data = ed; v.exp_err = er;
        return v;
    endfunction

    task automatic chk_bus(input vec_t v);
        chk1({v.name, " req"}, mem_req_o, 1'b1);
        chk({v.name, " addr"}, mem_addr_o, {v.addr[31:2], 2'b00});
        chk1({v.name, " wen"}, mem_wen_o, v.wr);
        chk({v.name, " wmask"}, 32'(mem_wmask_o), 32'(v.exp_mask));
        if (v.wr) chk({v.name, " wdata"}, mem_wdata_o, v.exp_wdata);
        chk1({v.name, " in_ready busy"}, in_ready_o, 1'b0);
    endtask

    // Waits for the result, pops the scoreboard and checks it, then consumes it.
    task automatic await_result(input int cyc0, input int exp_lat, input int hold, input string nm);
        int   cyc;
        exp_t e;
        cyc = cyc0;
        while (!out_valid_o && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", nm);
            return;
        end
        e = sb.pop_front();
        chk({e.name, " data"}, mem_data_o, e.data);
        chk1({e.name, " err"}, err_o, e.err);
        chk1({e.name, " req in done"}, mem_req_o, 1'b0);
        for (int h = 0; h < hold; h++) begin
            mem_rdata_i = $urandom;
            @(negedge clk);
            chk1({e.name, " held valid"}, out_valid_o, 1'b1);
            chk({e.name, " held data"}, mem_data_o, e.data);
            chk1({e.name, " held err"}, err_o, e.err);
            chk1({e.name, " held in_ready"}, in_ready_o, 1'b0);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        chk1({e.name, " released"}, out_valid_o, 1'b0);
        chk1({e.name, " in_ready after"}, in_ready_o, 1'b1);
    endtask

    task automatic drive_accept(input string n, input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input bit ordy);
        @(negedge clk);
        chk1({n, " in_ready"}, in_ready_o, 1'b1);
        in_valid_i  = 1'b1;
        addr_i      = a;
        wdata_i     = wd;
        funct3_i    = f3;
        mem_rd_i    = rd;
        mem_wr_i    = wr;
        out_ready_i = ordy;
        @(posedge clk);
    endtask

    task automatic scramble_inputs();
        in_valid_i = 1'b0;
        addr_i     = 32'hFFFF_FFFF;
        wdata_i    = 32'h5555_5555;
        funct3_i   = 3'b111;
        mem_rd_i   = 1'b0;
        mem_wr_i   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   cyc;
        int   lat;
        drive_accept(v.name, v.rd, v.wr, v.f3, v.addr, v.wdata, v.hold == 0);
        e.name = v.name; e.data = v.exp_data; e.err = v.exp_err;
        sb.push_back(e);
        @(negedge clk);
        scramble_inputs();
        cyc = 1;
        if (v.exp_req) begin
            for (int k = 0; k < v.gnt_dly; k++) begin
                chk_bus(v);
                @(negedge clk);
                cyc++;
            end
            chk_bus(v);
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = v.rv_same;
            mem_rdata_i  = v.rv_same ? v.rdata : 32'h0BAD_F00D;
            @(negedge clk);
            cyc++;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (!v.rv_same) begin
                chk1({v.name, " req in wait"}, mem_req_o, 1'b0);
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = v.rdata;
                @(negedge clk);
                cyc++;
                mem_rvalid_i = 1'b0;
            end
            mem_rdata_i = 32'h0BAD_F00D;
            lat = v.gnt_dly + (v.rv_same ? 2 : 3);
        end else begin
            chk1({v.name, " no req"}, mem_req_o, 1'b0);
            lat = 1;
        end
        await_result(cyc, lat, v.hold, v.name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        // name rd wr f3 addr wdata rdata gnt_dly rv_same hold req mask exp_wdata exp_data err
        vecs.push_back(mk("lw",       1, 0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 0, 1, 0, 1, 4'b0000, 32'h0,        32'hDEAD_BEEF, 0));
        vecs.push_back(mk("lb3",      1, 0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 1, 0, 1, 4'b0000, 32'h0,        32'hFFFF_FF80, 0));
        vecs.push_back(mk("lbu3",     1, 0, 3'b100, 32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 1, 0, 1, 4'b0000, 32'h0,        32'h0000_0080, 0));
        vecs.push_back(mk("lh2",      1, 0, 3'b001, 32'h8000_0002, 32'h0,        32'h80FF_1234, 0, 1, 0, 1, 4'b0000, 32'h0,        32'hFFFF_80FF, 0));
        vecs.push_back(mk("lhu2",     1, 0, 3'b101, 32'h8000_0002, 32'h0,        32'h80FF_1234, 0, 1, 0, 1, 4'b0000, 32'h0,        32'h0000_80FF, 0));
        vecs.push_back(mk("lb0",      1, 0, 3'b000, 32'h8000_0000, 32'h0,        32'h80FF_1234, 0, 1, 0, 1, 4'b0000, 32'h0,        32'h0000_0034, 0));
        vecs.push_back(mk("lh0",      1, 0, 3'b001, 32'h8000_0000, 32'h0,        32'h80FF_9234, 1, 1, 0, 1, 4'b0000, 32'h0,        32'hFFFF_9234, 0));
        vecs.push_back(mk("lb1_wait", 1, 0, 3'b000, 32'h8000_0001, 32'h0,        32'h0000_7F00, 2, 0, 0, 1, 4'b0000, 32'h0,        32'h0000_007F, 0));
        vecs.push_back(mk("sb1",      0, 1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0,       0, 1, 0, 1, 4'b0010, 32'hABAB_ABAB, 32'h0,        0));
        vecs.push_back(mk("sh2",      0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0,       1, 1, 0, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0));
        vecs.push_back(mk("sw8",      0, 1, 3'b010, 32'h8000_0008, 32'h1234_5678, 32'h0,       0, 1, 0, 1, 4'b1111, 32'h1234_5678, 32'h0,        0));
        vecs.push_back(mk("sb3_wait", 0, 1, 3'b000, 32'h8000_0003, 32'h0000_00C3, 32'h0,       1, 0, 0, 1, 4'b1000, 32'hC3C3_C3C3, 32'h0,        0));
        vecs.push_back(mk("sh1_mis",  0, 1, 3'b001, 32'h8000_0001, 32'h0000_1111, 32'h0,       0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,         1));
        vecs.push_back(mk("lw2_mis",  1, 0, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,         1));
        vecs.push_back(mk("lhu1_mis", 1, 0, 3'b101, 32'h8000_0001, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,         1));
        vecs.push_back(mk("nomem",    0, 0, 3'b010, 32'h8000_0001, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,         0));
        vecs.push_back(mk("rdwr",     1, 1, 3'b010, 32'h8000_0000, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,         1));
        vecs.push_back(mk("sbu_st",   0, 1, 3'b100, 32'h8000_0000, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,         1));
        vecs.push_back(mk("ld011",    1, 0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,         1));
        vecs.push_back(mk("lw_hold",  1, 0, 3'b010, 32'h8000_000C, 32'h0,        32'hCAFE_F00D, 3, 1, 2, 1, 4'b0000, 32'h0,        32'hCAFE_F00D, 0));
        vecs.push_back(mk("sw_hold",  0, 1, 3'b010, 32'h8000_0010, 32'hA5A5_A5A5, 32'h0,       3, 1, 2, 1, 4'b1111, 32'hA5A5_A5A5, 32'h0,        0));

        rst_n        = 1'b0;
        in_valid_i   = 1'b0;
        addr_i       = 32'h0;
        wdata_i      = 32'h0;
        funct3_i     = 3'b000;
        mem_rd_i     = 1'b0;
        mem_wr_i     = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        out_ready_i  = 1'b1;

        repeat (2) @(negedge clk);
        chk1("reset in_ready", in_ready_o, 1'b1);
        chk1("reset req", mem_req_o, 1'b0);
        chk1("reset wen", mem_wen_o, 1'b0);
        chk1("reset out_valid", out_valid_o, 1'b0);
        chk1("reset err", err_o, 1'b0);
        chk("reset addr", mem_addr_o, 32'h0);
        chk("reset wdata", mem_wdata_o, 32'h0);
        chk("reset wmask", 32'(mem_wmask_o), 32'h0);
        chk("reset data", mem_data_o, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Granted load whose response never arrives: must abort on the timeout.
        drive_accept("timeout", 1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'h0, 1'b1);
        e.name = "timeout"; e.data = 32'h0; e.err = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        scramble_inputs();
        chk1("timeout req", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk1("timeout wait req", mem_req_o, 1'b0);
        await_result(2, 256, 0, "timeout");

        // Reset asserted while waiting for a response abandons the access.
        drive_accept("rst_wait", 1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 1'b1);
        @(negedge clk);
        scramble_inputs();
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk1("rst_wait in wait", out_valid_o, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_wait req", mem_req_o, 1'b0);
        chk1("rst_wait wen", mem_wen_o, 1'b0);
        chk1("rst_wait out_valid", out_valid_o, 1'b0);
        chk1("rst_wait err", err_o, 1'b0);
        chk("rst_wait addr", mem_addr_o, 32'h0);
        chk("rst_wait data", mem_data_o, 32'h0);
        chk1("rst_wait in_ready", in_ready_o, 1'b1);
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1357_9BDF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("late rvalid in_ready", in_ready_o, 1'b1);
        chk1("late rvalid out_valid", out_valid_o, 1'b0);
        chk("late rvalid data", mem_data_o, 32'h0);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;

        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
